// File: rtl/mcs4_bus_sequencer.sv
// MCS-4 eight-slot instruction-cycle sequencer and multiplexed bus controller.
// Generates A1..X3 from sysclk, drives/samples the bus and asserts SYNC/CM strobes.
module mcs4_bus_sequencer #(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned NUM_CMRAM = 4,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned SLOT_CYC  = 4
) (
    input  logic                   sysclk,
    input  logic                   poc_n,
    input  logic                   hold,
    input  logic [3*DATA_W-1:0]    pc,
    input  logic                   io_cmd,
    input  logic                   src_cmd,
    input  logic                   wr_cmd,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [2*DATA_W-1:0]    src_data,
    input  logic                   dcl_en,
    input  logic [BANK_W-1:0]      dcl_val,
    input  logic [DATA_W-1:0]      data_in,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_dir,
    output logic [2*DATA_W-1:0]    opr_opa,
    output logic                   instr_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [7:0]             slot,
    output logic                   sync,
    output logic                   cmrom,
    output logic [NUM_CMRAM-1:0]   cmram
);

    localparam int unsigned CntW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    typedef enum logic [7:0] {
        SlotA1 = 8'h01,
        SlotA2 = 8'h02,
        SlotA3 = 8'h04,
        SlotM1 = 8'h08,
        SlotM2 = 8'h10,
        SlotX1 = 8'h20,
        SlotX2 = 8'h40,
        SlotX3 = 8'h80
    } slot_e;

    slot_e                 slot_q, slot_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  io_q, io_d, src_q, src_d, wr_q, wr_d;
    logic [DATA_W-1:0]     opr_q, opr_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic                  data_dir_q, data_dir_d;
    logic [2*DATA_W-1:0]   opr_opa_q, opr_opa_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0]     rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  sync_q, sync_d;
    logic                  cmrom_q, cmrom_d;
    logic [NUM_CMRAM-1:0]  cmram_q, cmram_d;

    logic slot_end;
    logic cm_line;

    assign slot_end = (cnt_q == CntW'(SLOT_CYC - 1));

    always_comb begin
        slot_d        = slot_q;
        cnt_d         = cnt_q;
        io_d          = io_q;
        src_d         = src_q;
        wr_d          = wr_q;
        opr_d         = opr_q;
        bank_d        = bank_q;
        data_out_d    = data_out_q;
        data_dir_d    = data_dir_q;
        opr_opa_d     = opr_opa_q;
        instr_valid_d = instr_valid_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = rd_valid_q;
        sync_d        = sync_q;
        cmrom_d       = cmrom_q;
        cmram_d       = cmram_q;
        cm_line       = 1'b0;

        // A held slot end freezes every register, outputs included.
        if (!(slot_end && hold)) begin
            instr_valid_d = 1'b0;
            rd_valid_d    = 1'b0;
            if (slot_end) begin
                cnt_d = '0;
                unique case (slot_q)
                    SlotA1: slot_d = SlotA2;
                    SlotA2: slot_d = SlotA3;
                    SlotA3: slot_d = SlotM1;
                    SlotM1: begin
                        slot_d = SlotM2;
                        io_d   = io_cmd;
                        src_d  = src_cmd;
                        wr_d   = wr_cmd;
                        opr_d  = data_in;
                    end
                    SlotM2: begin
                        slot_d        = SlotX1;
                        opr_opa_d     = {opr_q, data_in};
                        instr_valid_d = 1'b1;
                    end
                    SlotX1: slot_d = SlotX2;
                    SlotX2: begin
                        slot_d = SlotX3;
                        if (io_q && !src_q && !wr_q) begin
                            rd_data_d  = data_in;
                            rd_valid_d = 1'b1;
                        end
                    end
                    SlotX3: begin
                        slot_d = SlotA1;
                        if (dcl_en) begin
                            bank_d = dcl_val;
                        end
                    end
                    default: slot_d = SlotA1;
                endcase
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end

            // Outputs are computed for the slot being entered so they align with slot.
            data_dir_d = 1'b0;
            unique case (slot_d)
                SlotA1: begin
                    data_dir_d = 1'b1;
                    data_out_d = pc[DATA_W-1:0];
                end
                SlotA2: begin
                    data_dir_d = 1'b1;
                    data_out_d = pc[2*DATA_W-1:DATA_W];
                end
                SlotA3: begin
                    data_dir_d = 1'b1;
                    data_out_d = pc[3*DATA_W-1:2*DATA_W];
                end
                SlotX2: begin
                    if (src_d) begin
                        data_dir_d = 1'b1;
                        data_out_d = src_data[2*DATA_W-1:DATA_W];
                    end else if (wr_d) begin
                        data_dir_d = 1'b1;
                        data_out_d = wr_data;
                    end
                end
                SlotX3: begin
                    if (src_d) begin
                        data_dir_d = 1'b1;
                        data_out_d = src_data[DATA_W-1:0];
                    end
                end
                default: ;
            endcase

            cmrom_d = (slot_d == SlotA3) || ((slot_d == SlotM2) && io_d);
            cm_line = cmrom_d || ((slot_d == SlotX2) && src_d);
            for (int unsigned i = 0; i < NUM_CMRAM; i++) begin
                cmram_d[i] = cm_line && (bank_d == BANK_W'(i));
            end
            sync_d = (slot_d == SlotX3);
        end
    end

    always_ff @(posedge sysclk or negedge poc_n) begin
        if (!poc_n) begin
            slot_q        <= SlotA1;
            cnt_q         <= '0;
            io_q          <= 1'b0;
            src_q         <= 1'b0;
            wr_q          <= 1'b0;
            opr_q         <= '0;
            bank_q        <= '0;
            data_out_q    <= '0;
            data_dir_q    <= 1'b1;
            opr_opa_q     <= '0;
            instr_valid_q <= 1'b0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            sync_q        <= 1'b0;
            cmrom_q       <= 1'b0;
            cmram_q       <= '0;
        end else begin
            slot_q        <= slot_d;
            cnt_q         <= cnt_d;
            io_q          <= io_d;
            src_q         <= src_d;
            wr_q          <= wr_d;
            opr_q         <= opr_d;
            bank_q        <= bank_d;
            data_out_q    <= data_out_d;
            data_dir_q    <= data_dir_d;
            opr_opa_q     <= opr_opa_d;
            instr_valid_q <= instr_valid_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            sync_q        <= sync_d;
            cmrom_q       <= cmrom_d;
            cmram_q       <= cmram_d;
        end
    end

    assign slot        = slot_q;
    assign data_out    = data_out_q;
    assign data_dir    = data_dir_q;
    assign opr_opa     = opr_opa_q;
    assign instr_valid = instr_valid_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign sync        = sync_q;
    assign cmrom       = cmrom_q;
    assign cmram       = cmram_q;

endmodule
